// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Frame configuration is captured on the start event so the register block can change it mid-frame.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       start_tx,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_cnt, bit_d;
  logic [7:0]    data_sh;
  logic [1:0]    n_sh;
  logic          s_sh, p_sh, pt_sh;
  logic          start_q;
  logic          tx_d, busy_d, done_d, load;
  logic          baud_tc, start_ev, parity_bit;
  logic [2:0]    last_bit;

  assign baud_tc    = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign start_ev   = start_tx & ~start_q;
  // N-1 = 4 + data_bit_num, i.e. the encoding with a leading one.
  assign last_bit   = {1'b1, n_sh};
  assign parity_bit = (^(data_sh & (8'hFF >> (2'd3 - n_sh)))) ^ pt_sh;

  // NOTE: every output of this block gets a default first; without it any
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state;
    baud_d  = baud_tc ? '0 : baud_cnt + CW'(1);
    bit_d   = bit_cnt;
    tx_d    = tx;
    busy_d  = tx_busy;
    done_d  = tx_done;
    load    = 1'b0;
    case (state)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        bit_d  = '0;
        if (start_ev) begin
          load    = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      START: if (baud_tc) begin
        state_d = DATA;
        tx_d    = data_sh[0];
      end
      DATA: if (baud_tc) begin
        if (bit_cnt == last_bit) begin
          bit_d = '0;
          if (p_sh) begin
            state_d = PARITY;
            tx_d    = parity_bit;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d = bit_cnt + 3'd1;
          tx_d  = data_sh[bit_cnt + 3'd1];
        end
      end
      PARITY: if (baud_tc) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (baud_tc) begin
        if (bit_cnt == {2'b00, s_sh}) begin
          state_d = IDLE;
          bit_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          bit_d = bit_cnt + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      // A start_tx already high when reset lifts must not look like an edge.
      start_q  <= 1'b1;
      // NOTE: shadow registers are always loaded before use; resetting them
      // only keeps simulation free of X and costs nothing meaningful.
      data_sh  <= '0;
      n_sh     <= '0;
      s_sh     <= 1'b0;
      p_sh     <= 1'b0;
      pt_sh    <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      tx       <= tx_d;
      tx_busy  <= busy_d;
      tx_done  <= done_d;
      start_q  <= start_tx;
      if (load) begin
        data_sh <= tx_data;
        n_sh    <= data_bit_num;
        s_sh    <= stop_bit_num;
        p_sh    <= parity_en;
        pt_sh   <= parity_type;
      end
    end
  end

endmodule
